mos6502_bus_timer: RTL and testbench

MOS6502_BUS_TIMER -- requirements
Module: mos6502_bus_timer

---
 rtl/mos6502_bus_timer_pkg.sv | 20 ++
 rtl/mos6502_timer_core.sv | 95 +++++++++
 rtl/mos6502_bus_timer.sv | 89 ++++++++
 tb/tb_mos6502_bus_timer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mos6502_bus_timer_pkg.sv
// Shared register map, CTRL bit positions and bus FSM state type for the 6502 bus timer.
package mos6502_bus_timer_pkg;

    localparam logic [2:0] OFF_RELOAD_LO = 3'd0;
    localparam logic [2:0] OFF_RELOAD_HI = 3'd1;
    localparam logic [2:0] OFF_CTRL      = 3'd2;
    localparam logic [2:0] OFF_STAT      = 3'd3;
    localparam logic [2:0] OFF_SCRATCH   = 3'd4;

    localparam logic [1:0] CTRL_EN   = 2'd0;
    localparam logic [1:0] CTRL_CONT = 2'd1;
    localparam logic [1:0] CTRL_IE   = 2'd2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StAccess = 2'd2
    } bus_state_e;

endpackage

// File: rtl/mos6502_timer_core.sv
// Timer datapath and register file: COUNT/RELOAD/HSNAP/CTRL/IF/SCRATCH plus underflow logic.
module mos6502_timer_core
    import mos6502_bus_timer_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_wr,
    input  logic       i_rd,
    input  logic [2:0] i_offset,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_irq
);

    logic [15:0] r_count, r_reload;
    logic [7:0]  r_hsnap, r_scratch;
    logic [2:0]  r_ctrl;
    logic        r_if;

    logic [15:0] w_count_d, w_reload_d;
    logic [7:0]  w_hsnap_d, w_scratch_d;
    logic [2:0]  w_ctrl_d;
    logic        w_if_d;

    logic w_underflow, w_wr_lo, w_wr_hi, w_wr_ctrl, w_wr_stat, w_wr_scratch;

    assign w_underflow  = r_ctrl[CTRL_EN] & (r_count == 16'h0000);
    assign w_wr_lo      = i_wr & (i_offset == OFF_RELOAD_LO);
    assign w_wr_hi      = i_wr & (i_offset == OFF_RELOAD_HI);
    assign w_wr_ctrl    = i_wr & (i_offset == OFF_CTRL);
    assign w_wr_stat    = i_wr & (i_offset == OFF_STAT);
    assign w_wr_scratch = i_wr & (i_offset == OFF_SCRATCH);

    always_comb begin
        w_count_d   = r_count;
        w_reload_d  = r_reload;
        w_hsnap_d   = r_hsnap;
        w_scratch_d = r_scratch;
        w_ctrl_d    = r_ctrl;
        w_if_d      = r_if;

        if (w_wr_lo) w_reload_d[7:0] = i_wdata;
        if (w_wr_hi) w_reload_d[15:8] = i_wdata;

        if (r_ctrl[CTRL_EN]) begin
            if (!w_underflow)          w_count_d = r_count - 16'd1;
            else if (r_ctrl[CTRL_CONT]) w_count_d = r_reload;
            else                        w_count_d = 16'h0000;
        end
        // A high-byte write reloads COUNT and overrides any tick this cycle
        if (w_wr_hi) w_count_d = {i_wdata, r_reload[7:0]};

        if (w_wr_ctrl)                              w_ctrl_d = i_wdata[2:0];
        else if (w_underflow && !r_ctrl[CTRL_CONT]) w_ctrl_d[CTRL_EN] = 1'b0;

        if (w_underflow)                               w_if_d = 1'b1;
        else if (w_wr_hi || (w_wr_stat && i_wdata[0])) w_if_d = 1'b0;

        if (i_rd && (i_offset == OFF_RELOAD_LO)) w_hsnap_d = r_count[15:8];
        if (w_wr_scratch) w_scratch_d = i_wdata;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count   <= 16'h0000;
            r_reload  <= 16'hFFFF;
            r_hsnap   <= 8'h00;
            r_scratch <= 8'h00;
            r_ctrl    <= 3'b000;
            r_if      <= 1'b0;
        end else begin
            r_count   <= w_count_d;
            r_reload  <= w_reload_d;
            r_hsnap   <= w_hsnap_d;
            r_scratch <= w_scratch_d;
            r_ctrl    <= w_ctrl_d;
            r_if      <= w_if_d;
        end
    end

    always_comb begin
        o_rdata = 8'h00;
        case (i_offset)
            OFF_RELOAD_LO: o_rdata = r_count[7:0];
            OFF_RELOAD_HI: o_rdata = r_hsnap;
            OFF_CTRL:      o_rdata = {5'b00000, r_ctrl};
            OFF_STAT:      o_rdata = {7'b0000000, r_if};
            OFF_SCRATCH:   o_rdata = r_scratch;
            default:       o_rdata = 8'h00;
        endcase
    end

    assign o_irq = r_if & r_ctrl[CTRL_IE];

endmodule

// File: rtl/mos6502_bus_timer.sv
// 6502 bus responder: address decode and RDY wait-state FSM in front of the timer core.
module mos6502_bus_timer
    import mos6502_bus_timer_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'hD000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] ADDRESS,
    input  logic        RW,
    input  logic [7:0]  WDATA,
    output logic [7:0]  RDATA,
    output logic        DRIVE,
    output logic        RDY,
    output logic        IRQ
);

    // The IDLE cycle is itself the first RDY-low cycle, so WAIT covers the rest
    localparam logic [2:0] WS_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    bus_state_e r_state, w_state_d;
    logic [2:0] r_wcnt, w_wcnt_d;
    logic       w_sel, w_rdy, w_complete, w_commit;
    logic [7:0] w_core_rdata;

    assign w_sel = (ADDRESS[15:3] == BASE[15:3]);

    always_comb begin
        w_state_d  = r_state;
        w_wcnt_d   = r_wcnt;
        w_rdy      = 1'b1;
        w_complete = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_sel) begin
                    if (WAIT_STATES == 0) begin
                        w_complete = 1'b1;
                    end else begin
                        w_rdy     = 1'b0;
                        w_wcnt_d  = WS_INIT;
                        w_state_d = (WS_INIT == 3'd0) ? StAccess : StWait;
                    end
                end
            end
            StWait: begin
                if (!w_sel) begin
                    w_state_d = StIdle;
                end else begin
                    w_rdy    = 1'b0;
                    w_wcnt_d = r_wcnt - 3'd1;
                    if (w_wcnt_d == 3'd0) w_state_d = StAccess;
                end
            end
            StAccess: begin
                w_complete = 1'b1;
                w_state_d  = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_state_d;
            r_wcnt  <= w_wcnt_d;
        end
    end

    assign w_commit = w_complete & RST_N;
    assign RDY      = w_rdy | ~RST_N;
    assign DRIVE    = w_commit & RW;
    assign RDATA    = DRIVE ? w_core_rdata : 8'h00;

    mos6502_timer_core u_core (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_wr     (w_commit & ~RW),
        .i_rd     (w_commit & RW),
        .i_offset (ADDRESS[2:0]),
        .i_wdata  (WDATA),
        .o_rdata  (w_core_rdata),
        .o_irq    (IRQ)
    );

endmodule

// File: tb/tb_mos6502_bus_timer.sv
// Self-checking bench: per-cycle behavioural model plus directed literal scenarios and random traffic.
module tb_mos6502_bus_timer;

    localparam logic [15:0] BASE = 16'hD000;
    localparam int          WS   = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] ADDRESS = 16'h0000;
    logic        RW = 1'b1;
    logic [7:0]  WDATA = 8'h00;
    logic [7:0]  RDATA;
    logic        DRIVE, RDY, IRQ;

    int n_checks = 0;
    int n_errors = 0;

    mos6502_bus_timer #(
        .BASE        (BASE),
        .WAIT_STATES (WS)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ADDRESS (ADDRESS),
        .RW      (RW),
        .WDATA   (WDATA),
        .RDATA   (RDATA),
        .DRIVE   (DRIVE),
        .RDY     (RDY),
        .IRQ     (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents and elapsed RDY-low cycles of the current access
    logic [15:0] m_count, m_reload;
    logic [7:0]  m_hsnap, m_scratch;
    logic        m_en, m_cont, m_ie, m_if;
    int          m_low, m_low_next;
    logic        e_sel, e_comp, e_rdy, e_drive, e_irq, uf;
    logic [2:0]  e_off;
    logic [7:0]  e_rdata;

    function automatic logic [7:0] m_read(input logic [2:0] off);
        case (off)
            3'd0:    return m_count[7:0];
            3'd1:    return m_hsnap;
            3'd2:    return {5'b0, m_ie, m_cont, m_en};
            3'd3:    return {7'b0, m_if};
            3'd4:    return m_scratch;
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (!RST_N) begin
            check("rst_rdy", 16'(RDY), 16'h1);
            check("rst_drive", 16'(DRIVE), 16'h0);
            check("rst_rdata", 16'(RDATA), 16'h0);
            check("rst_irq", 16'(IRQ), 16'h0);
            m_count = 16'h0000; m_reload = 16'hFFFF; m_hsnap = 8'h00; m_scratch = 8'h00;
            m_en = 0; m_cont = 0; m_ie = 0; m_if = 0; m_low = 0;
        end else begin
            e_sel  = (ADDRESS[15:3] == BASE[15:3]);
            e_off  = ADDRESS[2:0];
            e_rdy  = 1'b1;
            e_comp = 1'b0;
            if (e_sel && m_low < WS) begin
                e_rdy = 1'b0;
                m_low_next = m_low + 1;
            end else begin
                e_comp = e_sel;
                m_low_next = 0;
            end
            e_drive = e_comp && RW;
            e_rdata = e_drive ? m_read(e_off) : 8'h00;
            e_irq   = m_if && m_ie;
            check("rdy", 16'(RDY), 16'(e_rdy));
            check("drive", 16'(DRIVE), 16'(e_drive));
            check("rdata", 16'(RDATA), 16'(e_rdata));
            check("irq", 16'(IRQ), 16'(e_irq));

            // Next state of the register model
            uf = m_en && (m_count == 16'h0000);
            if (e_comp && RW && e_off == 3'd0) m_hsnap = m_count[15:8];
            if (m_en) m_count = (m_count != 0) ? m_count - 16'd1 : (m_cont ? m_reload : 16'h0000);
            if (uf && !m_cont) m_en = 1'b0;
            if (e_comp && !RW) begin
                case (e_off)
                    3'd0: m_reload[7:0] = WDATA;
                    3'd1: begin
                        m_count = {WDATA, m_reload[7:0]};
                        m_reload[15:8] = WDATA;
                        m_if = 1'b0;
                    end
                    3'd2: {m_ie, m_cont, m_en} = WDATA[2:0];
                    3'd3: if (WDATA[0]) m_if = 1'b0;
                    3'd4: m_scratch = WDATA;
                    default: ;
                endcase
            end
            if (uf) m_if = 1'b1;
            m_low = m_low_next;
        end
    end

    task automatic xfer(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                        output logic [7:0] rd, output logic dv, output int low);
        bit done;
        low = 0; rd = 8'h00; dv = 1'b0; done = 0;
        ADDRESS = a; RW = rw; WDATA = wd;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge CLK);
            if (RDY) begin
                rd = RDATA; dv = DRIVE; done = 1;
            end else begin
                low++;
            end
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL xfer_timeout: RDY stuck low for addr %h", a);
        end
        @(posedge CLK); #1;
        ADDRESS = 16'h0000; RW = 1'b1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        logic [7:0] rd; logic dv; int low;
        xfer(BASE + 16'(off), 1'b0, d, rd, dv, low);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] rd; logic dv; int low;
        xfer(BASE + 16'(off), 1'b1, 8'h00, rd, dv, low);
        check(name, 16'(rd), 16'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd; logic dv; int low; int first;
        logic [15:0] a;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Reset values, and RELOAD=FFFF seen through a high-byte write
        rd_chk("rst_count_lo", 3'd0, 8'h00);
        rd_chk("rst_hsnap", 3'd1, 8'h00);
        rd_chk("rst_ctrl", 3'd2, 8'h00);
        rd_chk("rst_stat", 3'd3, 8'h00);
        rd_chk("rst_scratch", 3'd4, 8'h00);
        wr(3'd1, 8'h00);
        rd_chk("rst_reload_lo", 3'd0, 8'hFF);

        // Wait-state read of SCRATCH
        wr(3'd4, 8'h5A);
        xfer(BASE + 16'd4, 1'b1, 8'h00, rd, dv, low);
        check("ws_low_cycles", 16'(low), 16'd2);
        check("ws_drive", 16'(dv), 16'h1);
        check("ws_rdata", 16'(rd), 16'h005A);

        // COUNT snapshot read and out-of-window access
        wr(3'd0, 8'h34);
        wr(3'd1, 8'h12);
        rd_chk("count_lo_34", 3'd0, 8'h34);
        rd_chk("hsnap_12", 3'd1, 8'h12);
        xfer(BASE + 16'd8, 1'b1, 8'h00, rd, dv, low);
        check("unsel_low", 16'(low), 16'd0);
        check("unsel_drive", 16'(dv), 16'h0);

        // One-shot underflow from COUNT=3
        wr(3'd0, 8'h03);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h05);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (IRQ && first == 0) first = i;
        end
        @(posedge CLK); #1;
        check("oneshot_irq_cycle", 16'(first), 16'd5);
        rd_chk("oneshot_ctrl", 3'd2, 8'h04);
        rd_chk("oneshot_count", 3'd0, 8'h00);
        rd_chk("oneshot_stat", 3'd3, 8'h01);
        wr(3'd3, 8'h01);
        rd_chk("stat_cleared", 3'd3, 8'h00);

        // Continuous mode, period 3; the STAT clear lands on an underflow cycle
        wr(3'd0, 8'h02);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h01);
        rd_chk("set_wins_stat", 3'd3, 8'h01);
        for (int i = 0; i < 3; i++) rd_chk("cont_phase", 3'd0, 8'h00);
        wr(3'd2, 8'h04);
        @(negedge CLK);
        check("irq_level", 16'(IRQ), 16'h1);

        // Reset in the middle of a wait-stated access
        wr(3'd4, 8'hA5);
        @(posedge CLK); #1;
        ADDRESS = BASE + 16'd4; RW = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("wait_rdy_low", 16'(RDY), 16'h0);
        #2 RST_N = 1'b0;
        #1;
        check("async_rdy", 16'(RDY), 16'h1);
        check("async_drive", 16'(DRIVE), 16'h0);
        check("async_rdata", 16'(RDATA), 16'h0);
        check("async_irq", 16'(IRQ), 16'h0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1; ADDRESS = 16'h0000;
        rd_chk("post_count_lo", 3'd0, 8'h00);
        rd_chk("post_hsnap", 3'd1, 8'h00);
        rd_chk("post_ctrl", 3'd2, 8'h00);
        rd_chk("post_stat", 3'd3, 8'h00);
        rd_chk("post_scratch", 3'd4, 8'h00);
        wr(3'd1, 8'h00);
        rd_chk("post_reload_lo", 3'd0, 8'hFF);

        // Random traffic; the address is held through ACCESS, aborts only from WAIT
        for (int c = 0; c < 2000; c++) begin
            @(posedge CLK); #1;
            if (m_low == 0) begin
                if ($urandom_range(0, 9) < 3) begin
                    a = 16'($urandom);
                    if (a[15:3] == BASE[15:3]) a = a ^ 16'h8000;
                    ADDRESS = a;
                    RW = 1'($urandom_range(0, 1));
                end else begin
                    ADDRESS = BASE + 16'($urandom_range(0, 7));
                    RW = 1'($urandom_range(0, 1));
                    case (ADDRESS[2:0])
                        3'd0:    WDATA = 8'($urandom_range(0, 15));
                        3'd1:    WDATA = 8'($urandom_range(0, 1));
                        3'd2:    WDATA = 8'($urandom_range(0, 7));
                        default: WDATA = 8'($urandom);
                    endcase
                end
            end else if (m_low < WS && $urandom_range(0, 3) == 0) begin
                ADDRESS = 16'h0000;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
